// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state, display select and width definitions for stopwatch_ctrl
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam logic [1:0] SEL_RUN  = 2'b00;
    localparam logic [1:0] SEL_LAP1 = 2'b01;
    localparam logic [1:0] SEL_LAP2 = 2'b10;

    localparam int TIME_W_DEF = 16;

    // Cycle the display over valid entries only, wrapping back to running time.
    function automatic logic [1:0] next_view(input logic [1:0] sel, input logic [1:0] laps);
        logic [1:0] nxt;
        nxt = SEL_RUN;
        case (sel)
            SEL_RUN:  nxt = (laps >= 2'd1) ? SEL_LAP1 : SEL_RUN;
            SEL_LAP1: nxt = (laps == 2'd2) ? SEL_LAP2 : SEL_RUN;
            default:  nxt = SEL_RUN;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/view_timeout.sv
// rtl/view_timeout.sv - tick counter that strobes revert once a lap view has idled LIMIT ticks
module view_timeout #(
    parameter int LIMIT = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic active,
    input  logic restart,
    output logic revert
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    // restart (view press or clear) outranks a same-cycle expiry
    assign revert = active && tick && !restart && (count == CW'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (restart || !active || revert) begin
            count <= '0;
        end else if (tick) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - run/stop/clear sequencer with two lap registers and display select
// Optional display auto-revert built when STOPWATCH_VIEW_TIMEOUT_EN is defined.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TIME_W       = TIME_W_DEF,
    parameter int VIEW_TIMEOUT = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_stop_p,
    input  logic              lap_p,
    input  logic              clr_p,
    input  logic              view_p,
    input  logic              tick,
    input  logic [TIME_W-1:0] running_time,
    output logic              run_en,
    output logic              clear_time,
    output logic [TIME_W-1:0] lap1,
    output logic [TIME_W-1:0] lap2,
    output logic [1:0]        lap_count,
    output logic [1:0]        display_select
);

    state_t state;
    logic   clr_go;
    logic   revert;

    assign clr_go = (state == STOP) && clr_p;

`ifdef STOPWATCH_VIEW_TIMEOUT_EN
    view_timeout #(
        .LIMIT(VIEW_TIMEOUT)
    ) u_view_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick   (tick),
        .active (display_select != SEL_RUN),
        .restart(view_p | clr_go),
        .revert (revert)
    );
`else
    logic unused_cfg;
    assign revert     = 1'b0;
    assign unused_cfg = tick & (VIEW_TIMEOUT > 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            run_en         <= 1'b0;
            clear_time     <= 1'b0;
            lap1           <= '0;
            lap2           <= '0;
            lap_count      <= 2'd0;
            display_select <= SEL_RUN;
        end else begin
            clear_time <= 1'b0;

            // view uses the pre-capture lap_count; a clear below overrides it
            if (view_p) begin
                display_select <= next_view(display_select, lap_count);
            end else if (revert) begin
                display_select <= SEL_RUN;
            end

            case (state)
                IDLE: begin
                    if (start_stop_p) begin
                        state  <= RUN;
                        run_en <= 1'b1;
                    end
                end
                RUN: begin
                    if (lap_p) begin
                        case (lap_count)
                            2'd0: begin
                                lap1      <= running_time;
                                lap_count <= 2'd1;
                            end
                            2'd1: begin
                                lap2      <= running_time;
                                lap_count <= 2'd2;
                            end
                            default: begin
                                lap1 <= lap2;
                                lap2 <= running_time;
                            end
                        endcase
                    end
                    if (start_stop_p) begin
                        state  <= STOP;
                        run_en <= 1'b0;
                    end
                end
                STOP: begin
                    if (clr_go) begin
                        state          <= IDLE;
                        clear_time     <= 1'b1;
                        lap1           <= '0;
                        lap2           <= '0;
                        lap_count      <= 2'd0;
                        display_select <= SEL_RUN;
                    end else if (start_stop_p) begin
                        state  <= RUN;
                        run_en <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    run_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed and randomized check of stopwatch_ctrl against a queue-based model
module tb_stopwatch_ctrl;

    localparam int TW = 16;
    localparam int VT = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_stop_p, lap_p, clr_p, view_p, tick;
    logic [TW-1:0] running_time;
    logic          run_en, clear_time;
    logic [TW-1:0] lap1, lap2;
    logic [1:0]    lap_count, display_select;

    stopwatch_ctrl #(
        .TIME_W      (TW),
        .VIEW_TIMEOUT(VT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_stop_p  (start_stop_p),
        .lap_p         (lap_p),
        .clr_p         (clr_p),
        .view_p        (view_p),
        .tick          (tick),
        .running_time  (running_time),
        .run_en        (run_en),
        .clear_time    (clear_time),
        .lap1          (lap1),
        .lap2          (lap2),
        .lap_count     (lap_count),
        .display_select(display_select)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: mode 0 idle / 1 running / 2 stopped; laps holds the most recent two captures.
    int            m_mode = 0;
    logic [TW-1:0] m_laps[$];
    int            m_view = 0;
    int            m_tcnt = 0;
    logic          m_clear = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_laps.delete();
        m_view  = 0;
        m_tcnt  = 0;
        m_clear = 1'b0;
    endtask

    task automatic model_update(input logic ss, input logic lp, input logic cl,
                                input logic vw, input logic tk, input logic [TW-1:0] rt);
        int  old_n;
        bit  clr_ok;
        bit  expired;
        old_n   = m_laps.size();
        clr_ok  = (m_mode == 2) && cl;
        expired = 1'b0;
`ifdef STOPWATCH_VIEW_TIMEOUT_EN
        if (vw || clr_ok || m_view == 0) begin
            m_tcnt = 0;
        end else if (tk) begin
            m_tcnt = m_tcnt + 1;
            if (m_tcnt == VT) begin
                expired = 1'b1;
                m_tcnt  = 0;
            end
        end
`else
        if (tk) expired = 1'b0;
`endif
        if (vw) m_view = (m_view + 1) % (old_n + 1);
        else if (expired) m_view = 0;

        if (m_mode == 1 && lp) begin
            m_laps.push_back(rt);
            if (m_laps.size() > 2) void'(m_laps.pop_front());
        end

        m_clear = clr_ok;
        case (m_mode)
            0: if (ss) m_mode = 1;
            1: if (ss) m_mode = 2;
            default: begin
                if (clr_ok) begin
                    m_mode = 0;
                    m_laps.delete();
                    m_view = 0;
                end else if (ss) begin
                    m_mode = 1;
                end
            end
        endcase
    endtask

    task automatic check_all(input string tag);
        logic [TW-1:0] e1, e2;
        e1 = (m_laps.size() >= 1) ? m_laps[0] : '0;
        e2 = (m_laps.size() >= 2) ? m_laps[1] : '0;
        check({tag, ".run_en"},         32'(run_en),         32'(m_mode == 1));
        check({tag, ".clear_time"},     32'(clear_time),     32'(m_clear));
        check({tag, ".lap1"},           32'(lap1),           32'(e1));
        check({tag, ".lap2"},           32'(lap2),           32'(e2));
        check({tag, ".lap_count"},      32'(lap_count),      32'(m_laps.size()));
        check({tag, ".display_select"}, 32'(display_select), 32'(m_view));
    endtask

    task automatic step(input string tag, input logic ss, input logic lp, input logic cl,
                        input logic vw, input logic tk, input logic [TW-1:0] rt);
        @(negedge clk);
        start_stop_p = ss;
        lap_p        = lp;
        clr_p        = cl;
        view_p       = vw;
        tick         = tk;
        running_time = rt;
        @(posedge clk);
        model_update(ss, lp, cl, vw, tk, rt);
        #1;
        check_all(tag);
    endtask

    task automatic quiet_inputs();
        start_stop_p = 1'b0;
        lap_p        = 1'b0;
        clr_p        = 1'b0;
        view_p       = 1'b0;
        tick         = 1'b0;
        running_time = '0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".run_en"},         32'(run_en),         32'd0);
        check({tag, ".clear_time"},     32'(clear_time),     32'd0);
        check({tag, ".lap1"},           32'(lap1),           32'd0);
        check({tag, ".lap2"},           32'(lap2),           32'd0);
        check({tag, ".lap_count"},      32'(lap_count),      32'd0);
        check({tag, ".display_select"}, 32'(display_select), 32'd0);
    endtask

    initial begin
        quiet_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // start / stop / restart
        step("start",   1, 0, 0, 0, 0, 16'h0000);
        check("start.run_en_const", 32'(run_en), 32'd1);
        step("stop",    1, 0, 0, 0, 0, 16'h0000);
        check("stop.run_en_const", 32'(run_en), 32'd0);
        step("restart", 1, 0, 0, 0, 0, 16'h0000);

        // lap sequence including the shift case
        step("lap_a", 0, 1, 0, 0, 0, 16'h0012);
        step("lap_b", 0, 1, 0, 0, 0, 16'h0034);
        step("lap_c", 0, 1, 0, 0, 0, 16'h0056);
        check("lap_c.tuple", {lap1, lap2}, 32'h0034_0056);

        // clear ignored in RUN, honoured in STOP
        step("clr_in_run", 0, 0, 1, 0, 0, 16'h0060);
        step("stop2",      1, 0, 0, 0, 0, 16'h0061);
        step("clr_stop",   1, 0, 1, 0, 0, 16'h0062);
        check("clr_stop.clear_const", 32'(clear_time), 32'd1);
        step("after_clr",  0, 0, 0, 0, 0, 16'h0063);
        check("after_clr.clear_const", 32'(clear_time), 32'd0);

        // view cycling with one lap, then with none
        step("run3",   1, 0, 0, 0, 0, 16'h0100);
        step("lap1x",  0, 1, 0, 0, 0, 16'h0101);
        step("view_a", 0, 0, 0, 1, 0, 16'h0102);
        step("view_b", 0, 0, 0, 1, 0, 16'h0103);
        step("view_c", 0, 0, 0, 1, 0, 16'h0104);
        check("view_c.sel_const", 32'(display_select), 32'd1);
        step("stop3",  1, 0, 0, 0, 0, 16'h0105);
        step("clr3",   0, 0, 1, 0, 0, 16'h0106);
        step("view0",  0, 0, 0, 1, 0, 16'h0107);

`ifdef STOPWATCH_VIEW_TIMEOUT_EN
        step("to_run",  1, 0, 0, 0, 0, 16'h0200);
        step("to_lap1", 0, 1, 0, 0, 0, 16'h0201);
        step("to_lap2", 0, 1, 0, 0, 0, 16'h0202);
        step("to_v1",   0, 0, 0, 1, 0, 16'h0203);
        step("to_v2",   0, 0, 0, 1, 0, 16'h0204);
        for (int i = 0; i < 4; i++) step("to_tick", 0, 0, 0, 0, 1, 16'h0205);
        check("to_tick4.sel_const", 32'(display_select), 32'd2);
        step("to_tick5", 0, 0, 0, 0, 1, 16'h0206);
        check("to_tick5.sel_const", 32'(display_select), 32'd0);
        step("to_v3",   0, 0, 0, 1, 0, 16'h0207);
        for (int i = 0; i < 3; i++) step("to_pre", 0, 0, 0, 0, 1, 16'h0208);
        step("to_v4",   0, 0, 0, 1, 0, 16'h0209);
        for (int i = 0; i < 4; i++) step("to_post", 0, 0, 0, 0, 1, 16'h020a);
        check("to_post4.sel_const", 32'(display_select), 32'd2);
        step("to_post5", 0, 0, 0, 0, 1, 16'h020b);
        step("to_stop",  1, 0, 0, 0, 0, 16'h020c);
        step("to_clr",   0, 0, 1, 0, 0, 16'h020d);
`endif

        // asynchronous reset while running
        step("mr_run",  1, 0, 0, 0, 0, 16'h0300);
        step("mr_lap",  0, 1, 0, 0, 0, 16'h0301);
        step("mr_view", 0, 0, 0, 1, 0, 16'h0302);
        @(negedge clk);
        quiet_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // lap and stop together
        step("ls_run", 1, 0, 0, 0, 0, 16'h0400);
        step("ls_both", 1, 1, 0, 0, 0, 16'h0abc);
        check("ls_both.lap1_const", 32'(lap1), 32'h0abc);
        check("ls_both.run_const",  32'(run_en), 32'd0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            step("rand",
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 6) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) == 0,
                 TW'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
